// File: rtl/alu_rs_pool_if.sv
// ---------------------------------------------------------------------------
// alu_rs_pool_if
//   Bundles the three buses of the ALU reservation station pool:
//     - dispatch request (disp_*)   : decoded op, destination tag, operands
//     - CDB snoop channels (cdb_*)  : NCDB result broadcasts, packed per lane
//     - result / status (out_*, full)
//   master : driven by the dispatch stage / CDB side (testbench, core top)
//   slave  : the reservation station itself
// ---------------------------------------------------------------------------
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

interface alu_rs_pool_if #(
  parameter int ROB_W = `ROB_WIDTH,
  parameter int NCDB  = 2
);
  logic                   disp_valid;
  logic [5:0]             disp_op;
  logic [ROB_W-1:0]       disp_rob;
  logic [31:0]            disp_vj;
  logic [31:0]            disp_vk;
  logic                   disp_qj_valid;
  logic                   disp_qk_valid;
  logic [ROB_W-1:0]       disp_qj;
  logic [ROB_W-1:0]       disp_qk;

  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_W-1:0]  cdb_rob;
  logic [NCDB*32-1:0]     cdb_value;

  logic                   full;
  logic                   out_valid;
  logic [ROB_W-1:0]       out_rob;
  logic [31:0]            out_value;

  modport master (
    output disp_valid, disp_op, disp_rob, disp_vj, disp_vk,
           disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
           cdb_valid, cdb_rob, cdb_value,
    input  full, out_valid, out_rob, out_value
  );

  modport slave (
    input  disp_valid, disp_op, disp_rob, disp_vj, disp_vk,
           disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
           cdb_valid, cdb_rob, cdb_value,
    output full, out_valid, out_rob, out_value
  );
endinterface

// File: rtl/alu_rs_pool.sv
// ---------------------------------------------------------------------------
// alu_rs_pool
//   DEPTH-entry reservation station feeding a single-cycle ALU. Entries wait
//   for pending operands by snooping NCDB CDB channels, one ready entry is
//   issued per cycle, and its result is registered onto out_* with its ROB id.
//
// Ports
//   clk_in  : clock
//   rst_in  : synchronous active-low reset (priority over clear and rdy_in)
//   rdy_in  : global ready, low freezes every register
//   clear   : misprediction flush, empties the pool and kills out_valid
//   bus     : alu_rs_pool_if.slave (dispatch, CDB snoop, result, full)
//
// Configuration
//   ALU_RS_AGE_EN : when defined, each entry carries a wrapping age stamp
//                   and select picks the oldest ready entry; otherwise
//                   select picks the lowest-index ready entry.
//
// Op results (vj = rs1/pc, vk = rs2/imm as prepared by decode)
//   LUI -> vk; AUIPC/JAL/loads/stores/ADD(I) -> vj+vk; JALR -> (vj+vk)&~1;
//   branches -> all-ones when taken, else 0; remaining ops are the usual
//   RV32I register/immediate ALU operations.
// ---------------------------------------------------------------------------
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package alu_rs_pool_pkg;
  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND
  } op_e;
endpackage

module alu_rs_pool
  import alu_rs_pool_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = `ROB_WIDTH,
  parameter int NCDB  = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  alu_rs_pool_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [5:0]       op;
    logic [ROB_W-1:0] rob;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_valid;
    logic [ROB_W-1:0] qj;
    logic             qk_valid;
    logic [ROB_W-1:0] qk;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             out_valid_q, out_valid_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;
  logic [31:0]      out_value_q, out_value_d;

`ifdef ALU_RS_AGE_EN
  localparam int AW = IW + 1;
  logic [AW-1:0]    age_q [DEPTH];
  logic [AW-1:0]    age_d [DEPTH];
  logic [AW-1:0]    age_cnt_q, age_cnt_d;

  // Stamps live within half the counter range of each other, so the sign of
  // the modular difference tells which one was dispatched first.
  function automatic logic is_older(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] diff;
    diff = a - b;
    return diff[AW-1];
  endfunction
`endif

  logic [DEPTH-1:0] ready;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    free_idx;
  logic             fire;
  logic             issue;

  // Returns {hit, value} for a tag against all CDB lanes. Scanning from the
  // highest lane down lets the lowest matching lane overwrite the others.
  function automatic logic [32:0] snoop(
    input logic [ROB_W-1:0]      tag,
    input logic [NCDB-1:0]       v,
    input logic [NCDB*ROB_W-1:0] r,
    input logic [NCDB*32-1:0]    d
  );
    logic [32:0] res;
    res = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (v[c] && (r[c*ROB_W +: ROB_W] == tag)) res = {1'b1, d[c*32 +: 32]};
    end
    return res;
  endfunction

  function automatic logic [31:0] alu_eval(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] sum;
    sum = a + b;
    case (op_e'(op))
      OP_LUI:                     return b;
      OP_JALR:                    return {sum[31:1], 1'b0};
      OP_BEQ:                     return (a == b) ? '1 : '0;
      OP_BNE:                     return (a != b) ? '1 : '0;
      OP_BLT:                     return ($signed(a) <  $signed(b)) ? '1 : '0;
      OP_BGE:                     return ($signed(a) >= $signed(b)) ? '1 : '0;
      OP_BLTU:                    return (a <  b) ? '1 : '0;
      OP_BGEU:                    return (a >= b) ? '1 : '0;
      OP_SUB:                     return a - b;
      OP_SLT, OP_SLTI:            return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU, OP_SLTIU:          return {31'd0, a < b};
      OP_XOR, OP_XORI:            return a ^ b;
      OP_OR, OP_ORI:              return a | b;
      OP_AND, OP_ANDI:            return a & b;
      OP_SLL, OP_SLLI:            return a << b[4:0];
      OP_SRL, OP_SRLI:            return a >> b[4:0];
      OP_SRA, OP_SRAI:            return $signed(a) >>> b[4:0];
      OP_AUIPC, OP_JAL, OP_ADD, OP_ADDI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:        return sum;
      default:                    return '0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && !ent_q[i].qj_valid && !ent_q[i].qk_valid;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
`ifdef ALU_RS_AGE_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_valid || is_older(age_q[i], age_q[sel_idx]))) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
`endif
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin : next_state
    logic [32:0] hit;
    entry_t      new_ent;
    // NOTE: every variable gets a hold/default value before any branch so no
    // path leaves it unassigned and infers a latch.
    hit         = '0;
    new_ent     = '0;
    ent_d       = ent_q;
    busy_d      = busy_q;
    count_d     = count_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_rob_d   = out_rob_q;
    out_value_d = out_value_q;
    fire        = 1'b0;
    issue       = 1'b0;
`ifdef ALU_RS_AGE_EN
    age_d     = age_q;
    age_cnt_d = age_cnt_q;
`endif

    if (clear) begin
      busy_d      = '0;
      count_d     = '0;
      full_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      // Wakeup of resident entries.
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && ent_q[i].qj_valid) begin
          hit = snoop(ent_q[i].qj, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
          if (hit[32]) begin
            ent_d[i].vj       = hit[31:0];
            ent_d[i].qj_valid = 1'b0;
          end
        end
        if (busy_q[i] && ent_q[i].qk_valid) begin
          hit = snoop(ent_q[i].qk, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
          if (hit[32]) begin
            ent_d[i].vk       = hit[31:0];
            ent_d[i].qk_valid = 1'b0;
          end
        end
      end

      // Issue: the selected entry has no pending operand, so wakeup above
      // never touches it.
      issue       = sel_valid;
      out_valid_d = sel_valid;
      if (sel_valid) begin
        busy_d[sel_idx] = 1'b0;
        out_rob_d       = ent_q[sel_idx].rob;
        out_value_d     = alu_eval(ent_q[sel_idx].op, ent_q[sel_idx].vj, ent_q[sel_idx].vk);
      end

      // Dispatch into the lowest free slot, catching same-cycle broadcasts.
      fire = bus.disp_valid && !full_q;
      if (fire) begin
        new_ent.op       = bus.disp_op;
        new_ent.rob      = bus.disp_rob;
        new_ent.vj       = bus.disp_vj;
        new_ent.vk       = bus.disp_vk;
        new_ent.qj_valid = bus.disp_qj_valid;
        new_ent.qj       = bus.disp_qj;
        new_ent.qk_valid = bus.disp_qk_valid;
        new_ent.qk       = bus.disp_qk;
        hit = snoop(bus.disp_qj, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        if (bus.disp_qj_valid && hit[32]) begin
          new_ent.vj       = hit[31:0];
          new_ent.qj_valid = 1'b0;
        end
        hit = snoop(bus.disp_qk, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        if (bus.disp_qk_valid && hit[32]) begin
          new_ent.vk       = hit[31:0];
          new_ent.qk_valid = 1'b0;
        end
        ent_d[free_idx]  = new_ent;
        busy_d[free_idx] = 1'b1;
`ifdef ALU_RS_AGE_EN
        age_d[free_idx] = age_cnt_q;
        age_cnt_d       = age_cnt_q + 1'b1;
`endif
      end

      count_d = count_q + CW'(fire) - CW'(issue);
      full_d  = (count_d == CW'(DEPTH));
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_value_q <= '0;
`ifdef ALU_RS_AGE_EN
      age_cnt_q   <= '0;
`endif
    end else if (rdy_in) begin
      busy_q      <= busy_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_rob_q   <= out_rob_d;
      out_value_q <= out_value_d;
`ifdef ALU_RS_AGE_EN
      age_cnt_q   <= age_cnt_d;
`endif
    end
  end

  // NOTE: entry payload is deliberately not reset; busy_q qualifies it, and
  // leaving the storage reset-free keeps it a plain register array.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      ent_q <= ent_d;
`ifdef ALU_RS_AGE_EN
      age_q <= age_d;
`endif
    end
  end

  assign bus.full      = full_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rob   = out_rob_q;
  assign bus.out_value = out_value_q;

endmodule

// File: tb/tb_alu_rs_pool.sv
// ---------------------------------------------------------------------------
// tb_alu_rs_pool
//   Directed scenarios (reset, latency, wakeup, fill, flush, ordering)
//   followed by randomized dispatch/CDB/rdy/clear traffic. Expected results
//   are computed when an op is accepted and queued; a negedge monitor matches
//   every presented result against the queue by ROB id.
// ---------------------------------------------------------------------------
module tb_alu_rs_pool;
  import alu_rs_pool_pkg::*;

  localparam int DEPTH = 8;
  localparam int ROB_W = 4;
  localparam int NCDB  = 2;
  localparam int NTAG  = 1 << ROB_W;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [31:0]      val;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;
  logic live_edge = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [31:0] tag_val [NTAG];

  always #5 clk_in = ~clk_in;

  alu_rs_pool_if #(.ROB_W(ROB_W), .NCDB(NCDB)) bus();

  alu_rs_pool #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  // Reference ALU: straight from the op definitions.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op_e'(op))
      OP_LUI:                return b;
      OP_JALR:               return (a + b) & 32'hFFFF_FFFE;
      OP_BEQ:                return (a == b) ? 32'hFFFF_FFFF : 32'h0;
      OP_BNE:                return (a != b) ? 32'hFFFF_FFFF : 32'h0;
      OP_BLT:                return (sa < sb) ? 32'hFFFF_FFFF : 32'h0;
      OP_BGE:                return (sa >= sb) ? 32'hFFFF_FFFF : 32'h0;
      OP_BLTU:               return (a < b) ? 32'hFFFF_FFFF : 32'h0;
      OP_BGEU:               return (a >= b) ? 32'hFFFF_FFFF : 32'h0;
      OP_SUB:                return a - b;
      OP_SLT, OP_SLTI:       return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU:     return (a < b) ? 32'd1 : 32'd0;
      OP_XOR, OP_XORI:       return a ^ b;
      OP_OR, OP_ORI:         return a | b;
      OP_AND, OP_ANDI:       return a & b;
      OP_SLL, OP_SLLI:       return a << sh;
      OP_SRL, OP_SRLI:       return a >> sh;
      OP_SRA, OP_SRAI:       return 32'(sa >>> sh);
      default:               return a + b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    bus.disp_valid    = 1'b0;
    bus.disp_op       = '0;
    bus.disp_rob      = '0;
    bus.disp_vj       = '0;
    bus.disp_vk       = '0;
    bus.disp_qj_valid = 1'b0;
    bus.disp_qk_valid = 1'b0;
    bus.disp_qj       = '0;
    bus.disp_qk       = '0;
    bus.cdb_valid     = '0;
    bus.cdb_rob       = '0;
    bus.cdb_value     = '0;
    clear             = 1'b0;
  endtask

  // Drives a dispatch; queues the expected result only if it will be taken.
  task automatic dispatch(input logic [5:0] op, input logic [ROB_W-1:0] rob,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjv, input logic [ROB_W-1:0] qj,
                          input logic qkv, input logic [ROB_W-1:0] qk);
    exp_t e;
    bus.disp_valid    = 1'b1;
    bus.disp_op       = op;
    bus.disp_rob      = rob;
    bus.disp_vj       = vj;
    bus.disp_vk       = vk;
    bus.disp_qj_valid = qjv;
    bus.disp_qj       = qj;
    bus.disp_qk_valid = qkv;
    bus.disp_qk       = qk;
    if (!bus.full && rdy_in && !clear) begin
      e.rob = rob;
      e.val = ref_alu(op, qjv ? tag_val[qj] : vj, qkv ? tag_val[qk] : vk);
      exp_q.push_back(e);
    end
  endtask

  task automatic broadcast(input int ch, input logic [ROB_W-1:0] tag);
    bus.cdb_valid[ch]              = 1'b1;
    bus.cdb_rob[ch*ROB_W +: ROB_W] = tag;
    bus.cdb_value[ch*32 +: 32]     = tag_val[tag];
  endtask

  function automatic bit rob_live(input logic [ROB_W-1:0] rob);
    foreach (exp_q[i]) if (exp_q[i].rob == rob) return 1'b1;
    return 1'b0;
  endfunction

  // Keeps waking every tag until all queued results have come out.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      drive_idle();
      rdy_in = 1'b1;
      broadcast(0, ROB_W'(2 * (n % (NTAG / 2))));
      broadcast(1, ROB_W'(2 * (n % (NTAG / 2)) + 1));
      n++;
    end
    step();
    drive_idle();
    step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // A result is new only when the preceding edge actually updated state.
  always @(posedge clk_in) live_edge <= rdy_in && rst_in;

  always @(negedge clk_in) begin
    int idx;
    idx = -1;
    if (live_edge && bus.out_valid) begin
      foreach (exp_q[i]) if (idx < 0 && exp_q[i].rob == bus.out_rob) idx = i;
      if (idx < 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got rob %0d value 0x%08h, required no result",
                 bus.out_rob, bus.out_value);
      end else begin
        check("sb_value", bus.out_value, exp_q[idx].val);
        exp_q.delete(idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [ROB_W-1:0] rob_ctr;
    bit               do_clear;
    rob_ctr = '0;
    foreach (tag_val[i]) tag_val[i] = $urandom;
    tag_val[6] = 32'd10;
    tag_val[7] = 32'h77;

    // Reset with a dispatch request held high.
    rst_in = 1'b0;
    rdy_in = 1'b1;
    drive_idle();
    bus.disp_valid = 1'b1;
    bus.disp_op    = OP_ADD;
    bus.disp_rob   = 4'd1;
    repeat (2) begin
      step();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_full", 32'(bus.full), 32'd0);
    end
    check("rst_out_rob", 32'(bus.out_rob), 32'd0);
    check("rst_out_value", bus.out_value, 32'd0);
    rst_in = 1'b1;
    drive_idle();
    repeat (3) begin
      step();
      check("rst_no_entry", 32'(bus.out_valid), 32'd0);
    end

    // ADD with ready operands: result two cycles after dispatch.
    dispatch(OP_ADD, 4'd3, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0);
    step(); drive_idle();
    check("add_t1_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("add_t2_valid", 32'(bus.out_valid), 32'd1);
    check("add_rob", 32'(bus.out_rob), 32'd3);
    check("add_value", bus.out_value, 32'd12);

    dispatch(OP_SRA, 4'd4, 32'h8000_0000, 32'd4, 1'b0, '0, 1'b0, '0);
    step(); drive_idle();
    step();
    check("sra_valid", 32'(bus.out_valid), 32'd1);
    check("sra_value", bus.out_value, 32'hF800_0000);

    // SUB waiting on tag 6, woken by CDB lane 1.
    dispatch(OP_SUB, 4'd5, 32'hDEAD_BEEF, 32'd1, 1'b1, 4'd6, 1'b0, '0);
    step(); drive_idle();
    step();
    check("wake_pending", 32'(bus.out_valid), 32'd0);
    broadcast(1, 4'd6);
    step(); drive_idle();
    check("wake_t1_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("wake_t2_valid", 32'(bus.out_valid), 32'd1);
    check("wake_value", bus.out_value, 32'd9);

    // Same-cycle CDB match on the dispatch cycle.
    dispatch(OP_SUB, 4'd6, 32'h0, 32'd1, 1'b1, 4'd6, 1'b0, '0);
    broadcast(1, 4'd6);
    step(); drive_idle();
    step();
    check("samecyc_valid", 32'(bus.out_valid), 32'd1);
    check("samecyc_value", bus.out_value, 32'd9);

    // Two lanes hit the same tag: lane 0 value must be taken.
    dispatch(OP_ADD, 4'd7, 32'h0, 32'd0, 1'b1, 4'd7, 1'b0, '0);
    step(); drive_idle();
    broadcast(0, 4'd7);
    bus.cdb_valid[1]     = 1'b1;
    bus.cdb_rob[7:4]     = 4'd7;
    bus.cdb_value[63:32] = 32'hBAD0_BAD0;
    step(); drive_idle();
    step();
    check("lane_prio_value", bus.out_value, 32'h77);
    drain("drain_directed");

    // Fill every entry with ops pending on tags 8..15.
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_not_full", 32'(bus.full), 32'd0);
      dispatch(OP_ADD, ROB_W'(i), 32'h0, 32'(i), 1'b1, ROB_W'(8 + i), 1'b0, '0);
      step(); drive_idle();
    end
    check("fill_full", 32'(bus.full), 32'd1);
    dispatch(OP_ADD, 4'd15, 32'd1, 32'd2, 1'b0, '0, 1'b0, '0);
    step(); drive_idle();
    check("full_ignored_full", 32'(bus.full), 32'd1);
    broadcast(0, 4'd8);
    step(); drive_idle();
    check("full_before_issue", 32'(bus.full), 32'd1);
    check("full_no_result", 32'(bus.out_valid), 32'd0);
    step();
    check("full_issue_valid", 32'(bus.out_valid), 32'd1);
    check("full_issue_rob", 32'(bus.out_rob), 32'd0);
    check("full_cleared", 32'(bus.full), 32'd0);
    drain("drain_fill");

    // Flush four pending entries.
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_OR, ROB_W'(8 + i), 32'h0, 32'h1, 1'b1, ROB_W'(8 + i), 1'b0, '0);
      step(); drive_idle();
    end
    clear = 1'b1;
    @(negedge clk_in); #1;
    exp_q.delete();
    step(); drive_idle();
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_full", 32'(bus.full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      broadcast(i % 2, ROB_W'(8 + i));
      step(); drive_idle();
      check("flush_no_result", 32'(bus.out_valid), 32'd0);
    end
    repeat (3) begin
      step();
      check("flush_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Ordering: A in entry 2, B later in entry 0, both woken together.
    dispatch(OP_ADD, 4'd0, 32'h0, 32'd1, 1'b1, 4'd10, 1'b0, '0);
    step(); drive_idle();
    dispatch(OP_ADD, 4'd1, 32'h0, 32'd2, 1'b1, 4'd11, 1'b0, '0);
    step(); drive_idle();
    dispatch(OP_ADD, 4'd2, 32'h0, 32'd100, 1'b1, 4'd12, 1'b0, '0);
    step(); drive_idle();
    broadcast(0, 4'd10);
    step(); drive_idle();
    step();
    check("order_free_rob", 32'(bus.out_rob), 32'd0);
    dispatch(OP_ADD, 4'd3, 32'h0, 32'd200, 1'b1, 4'd12, 1'b0, '0);
    step(); drive_idle();
    broadcast(1, 4'd12);
    step(); drive_idle();
    step();
`ifdef ALU_RS_AGE_EN
    check("order_first", 32'(bus.out_rob), 32'd2);
    step();
    check("order_second", 32'(bus.out_rob), 32'd3);
`else
    check("order_first", 32'(bus.out_rob), 32'd3);
    step();
    check("order_second", 32'(bus.out_rob), 32'd2);
`endif
    drain("drain_order");

    // Randomized traffic.
    foreach (tag_val[i]) tag_val[i] = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      drive_idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      for (int ch = 0; ch < NCDB; ch++) begin
        if ($urandom_range(0, 99) < 40) broadcast(ch, ROB_W'($urandom_range(0, NTAG - 1)));
      end
      do_clear = rdy_in && ($urandom_range(0, 199) == 0);
      if (do_clear) begin
        clear = 1'b1;
      end else if (rdy_in && !bus.full && $urandom_range(0, 9) < 7 && !rob_live(rob_ctr)) begin
        dispatch(6'($urandom_range(0, 36)), rob_ctr, $urandom, $urandom,
                 1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, NTAG - 1)),
                 1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, NTAG - 1)));
        rob_ctr = rob_ctr + 1'b1;
      end
      if (do_clear) begin
        @(negedge clk_in); #1;
        exp_q.delete();
      end
    end
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs_pool.md
# alu_rs_pool

Multi-entry reservation station plus single-cycle ALU for the out-of-order core, sitting between the dispatch stage and the common data bus (CDB). Holds up to DEPTH decoded ALU/branch/jump ops whose operands may still be pending on ROB tags. Snoops NCDB result channels for wakeup, issues one ready entry per cycle to the internal ALU, and presents a registered result tagged with its ROB id. Supports a speculation flush.

## Interface
Parameters:
- DEPTH, 8: number of entries (power of two, 2..32).
- ROB_W, `ROB_WIDTH: ROB tag width.
- NCDB, 2: number of CDB snoop channels.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; one clock, reset is synchronous and active-low.
- rdy_in  in  1  global ready; low freezes every register.
- clear  in  1  misprediction flush.
- disp_valid  in  1  dispatch request.
- disp_op  in  6  op index in the core's op encoding (LUI..AND).
- disp_rob  in  ROB_W  destination ROB id.
- disp_vj, disp_vk  in  32  operand values.
- disp_qj_valid, disp_qk_valid  in  1  operand pending on a tag.
- disp_qj, disp_qk  in  ROB_W  producing ROB tags.
- cdb_valid  in  NCDB  per-channel result valid.
- cdb_rob  in  NCDB*ROB_W  per-channel ROB tag, channel i at [i*ROB_W +: ROB_W].
- cdb_value  in  NCDB*32  per-channel value.
- full  out  1  no free entry (registered).
- out_valid  out  1  result valid, one cycle per issued op.
- out_rob  out  ROB_W  ROB id of result.
- out_value  out  32  result: same op semantics as the existing single-op ALU. Branches return all-ones for taken, zero otherwise. JALR clears bit 0.

## Operation
- Entry fields: busy, op, rob, vj, vk, qj_valid, qj, qk_valid, qk, age.
- Dispatch: when disp_valid && !full, write the lowest-index non-busy entry.
  - Each pending operand is compared against all CDB channels in the same cycle. On a match, the CDB value is captured and the operand is marked ready.
- Wakeup: each cycle, every busy entry with a pending operand compares its tag against each valid CDB channel. On a match, it latches the value and clears the q flag. If several channels match, the lowest channel index wins.
- Ready: busy && !qj_valid && !qk_valid.
- Select: one ready entry per cycle (policy under Configuration). The selected entry is computed combinationally from its registered operands, freed, and its result registered onto out_*.
- Entry count: +1 on dispatch, -1 on issue, net 0 when both occur in the same cycle. full = (count == DEPTH).
- Dispatch while full is ignored; the upstream stage must hold the request.
- clear (with rdy_in high): all busy bits cleared, count = 0, out_valid = 0 next cycle. Dispatch, wakeup and issue in that cycle are discarded.
- rdy_in low: all state and outputs hold.
- Reset (rst_in low at a clock edge): busy = 0, count = 0, full = 0, out_valid = 0, out_rob = 0, out_value = 0. Reset has priority over clear and over rdy_in.
- Arithmetic: 32-bit wrap-around. Shifts use rhs[4:0]. SRA/SRAI are arithmetic. SLT/BLT/BGE are signed.

## Timing
- Dispatch with both operands ready at cycle t: eligible at t+1, out_valid at t+2 at the earliest.
- CDB match at cycle t: entry eligible at t+1.
- Issue-to-result latency is 1 cycle. Throughput is 1 result per cycle.
- full updates the cycle after the dispatch or issue that changes count.
- out_valid is high for exactly one cycle per issued op.

## Configuration
- ALU_RS_AGE_EN defined:
  - Each entry stores an age stamp from a ROB_W-independent wrapping counter of width log2(DEPTH)+1, incremented per dispatch.
  - Select picks the oldest ready entry. Age comparisons use a wrap-aware (modulo) comparison.
- ALU_RS_AGE_EN undefined:
  - No age storage.
  - Select picks the lowest-index ready entry.

## Test plan
- Reset: hold rst_in low 2 cycles with disp_valid=1 -> out_valid=0, full=0, no entry written.
- Ready dispatch: ADD vj=5, vk=7, rob=3 at t -> out_valid at t+2 with out_rob=3, out_value=12. Also SRA vj=0x80000000, vk=4 -> 0xF8000000.
- Wakeup: SUB with qj=6 pending, vk=1; CDB channel 1 broadcasts rob 6, value 10 at t -> result 9 at t+2. A same-cycle CDB match on the dispatch cycle also yields 9.
- Fill: DEPTH dispatches with operands pending -> full=1; the next dispatch is ignored. One wakeup then issue -> full=0 the cycle after the issue.
- Flush: 4 busy entries, clear=1 -> out_valid=0 the following cycle, count=0, subsequent wakeups produce no result.
- Ordering (ALU_RS_AGE_EN): dispatch A into entry 2, free entry 0, dispatch B into entry 0, make both ready the same cycle -> A issues first. Without the macro, B issues first.
